alu_mdu: RTL

Parametrised execute-stage arithmetic unit for the pipelined MIPS datapath. It extends the 4-op ALU into two parts:
- a combinational ALU with 12 operations, a zero flag and a signed overflow flag;
- a multi-cycle multiply/divide unit (MDU) that owns the HI/LO registers and exposes a busy signal, which hazard control uses to stall.

---
 rtl/alu_mdu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
`timescale 1ns/1ps
// Execute-stage ALU (12 ops, zero/overflow) plus a multi-cycle multiply/divide unit owning HI/LO.
// ALU is combinational; MDU ops hold busy for N cycles, and starts while busy are dropped (no queueing).
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUA,
    input  logic [WIDTH-1:0] ALUB,
    input  logic [3:0]       ALUctr,
    output logic [WIDTH-1:0] ALUout,
    output logic             zero,
    output logic             overflow,
    input  logic [2:0]       MDUop,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int SW   = $clog2(WIDTH);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [WIDTH-1:0] sum, diff;
    logic [SW-1:0]    shamt;

    assign sum   = ALUA + ALUB;
    assign diff  = ALUA - ALUB;
    assign shamt = ALUA[SW-1:0];
    assign zero  = (ALUA == ALUB);

    always_comb begin
        ALUout   = '0;
        overflow = 1'b0;
        case (ALUctr)
            4'd0: begin
                ALUout   = sum;
                overflow = (ALUA[WIDTH-1] == ALUB[WIDTH-1]) && (sum[WIDTH-1] != ALUA[WIDTH-1]);
            end
            4'd1: begin
                ALUout   = diff;
                overflow = (ALUA[WIDTH-1] != ALUB[WIDTH-1]) && (diff[WIDTH-1] != ALUA[WIDTH-1]);
            end
            4'd2:  ALUout = ALUA | ALUB;
            4'd3:  ALUout = ALUA & ALUB;
            4'd4:  ALUout = ALUA ^ ALUB;
            4'd5:  ALUout = ~(ALUA | ALUB);
            4'd6:  ALUout = {{(WIDTH-1){1'b0}}, $signed(ALUA) < $signed(ALUB)};
            4'd7:  ALUout = {{(WIDTH-1){1'b0}}, ALUA < ALUB};
            4'd8:  ALUout = ALUB << shamt;
            4'd9:  ALUout = ALUB >> shamt;
            4'd10: ALUout = $unsigned($signed(ALUB) >>> shamt);
            4'd11: ALUout = ALUB << (WIDTH / 2);
            default: ALUout = '0;
        endcase
    end

    // op_q[1]: divide (else multiply); op_q[0]: unsigned variant
    logic             busy_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;

    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quot, rem;

    // Multiplying the 2W-bit extended operands gives the correct low 2W bits for both signednesses
    always_comb begin
        ext_a = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod  = ext_a * ext_b;
    end

    // Sign-magnitude division: truncation toward zero, remainder follows the dividend.
    // MIN / -1 falls out naturally as quotient MIN, remainder 0.
    always_comb begin
        neg_a = ~op_q[0] & a_q[WIDTH-1];
        neg_b = ~op_q[0] & b_q[WIDTH-1];
        mag_a = neg_a ? -a_q : a_q;
        mag_b = neg_b ? -b_q : b_q;
        q_mag = '0;
        r_mag = '0;
        if (mag_b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem  = neg_a ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (busy_q) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy_q <= 1'b0;
                if (!op_q[1]) begin
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
                end else if (b_q != '0) begin
                    hi_q <= rem;
                    lo_q <= quot;
                end
            end
        end else if (start) begin
            case (MDUop)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    op_q   <= MDUop[1:0];
                    a_q    <= ALUA;
                    b_q    <= ALUB;
                    busy_q <= 1'b1;
                    cnt    <= MDUop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
                3'd4:    hi_q <= ALUA;
                3'd5:    lo_q <= ALUA;
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
